// File: rtl/rf_multiport.sv
// Multi-port CPU register file: NREAD combinational read ports with write-through
// bypass, one write port, and a per-register pending scoreboard with live count.
module rf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*ADDR_W-1:0]   ra,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rpend,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wa,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      rsv_en,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [ADDR_W:0]           pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic              wr_ok;
    logic              rsv_ok;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    assign wr_ok  = we && (wa != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // Reserve is applied after the write release so a same-register reserve wins.
    always_comb begin
        pend_next = pend;
        if (wr_ok) begin
            pend_next[wa] = 1'b0;
        end
        if (rsv_ok) begin
            pend_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= popcount(pend_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wdata;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic              zero;

        assign a    = ra[g*ADDR_W +: ADDR_W];
        assign zero = (a == '0);
        assign hit  = we && (wa == a);

        assign rdata[g*DATA_W +: DATA_W] = zero ? '0 : (hit ? wdata : mem[a]);
        assign rpend[g] = !zero && pend[a] && !hit;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomized bench for rf_multiport: a default 32/5/2 instance and a small 16/3/3
// instance, both checked against array-based reference models every cycle.
module tb_rf_multiport;

    localparam int MD = 32, MA = 5, MN = 2;
    localparam int SD = 16, SA = 3, SN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [MN*MA-1:0] m_ra;
    logic [MN*MD-1:0] m_rdata;
    logic [MN-1:0]    m_rpend;
    logic             m_we, m_rsv;
    logic [MA-1:0]    m_wa, m_rsva;
    logic [MD-1:0]    m_wd;
    logic [MA:0]      m_cnt;

    logic [SN*SA-1:0] s_ra;
    logic [SN*SD-1:0] s_rdata;
    logic [SN-1:0]    s_rpend;
    logic             s_we, s_rsv;
    logic [SA-1:0]    s_wa, s_rsva;
    logic [SD-1:0]    s_wd;
    logic [SA:0]      s_cnt;

    rf_multiport #(.DATA_W(MD), .ADDR_W(MA), .NREAD(MN)) dut (
        .clk(clk), .rst(rst), .ra(m_ra), .rdata(m_rdata), .rpend(m_rpend),
        .we(m_we), .wa(m_wa), .wdata(m_wd), .rsv_en(m_rsv), .rsv_addr(m_rsva),
        .pend_cnt(m_cnt)
    );

    rf_multiport #(.DATA_W(SD), .ADDR_W(SA), .NREAD(SN)) dut_s (
        .clk(clk), .rst(rst), .ra(s_ra), .rdata(s_rdata), .rpend(s_rpend),
        .we(s_we), .wa(s_wa), .wdata(s_wd), .rsv_en(s_rsv), .rsv_addr(s_rsva),
        .pend_cnt(s_cnt)
    );

    // Reference state: register contents and the set of pending registers.
    bit [MD-1:0] mm [2**MA];
    bit          mp [2**MA];
    bit [SD-1:0] sm [2**SA];
    bit          sp [2**SA];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int count_m();
        int c = 0;
        for (int i = 0; i < 2**MA; i++) c += int'(mp[i]);
        return c;
    endfunction

    function automatic int count_s();
        int c = 0;
        for (int i = 0; i < 2**SA; i++) c += int'(sp[i]);
        return c;
    endfunction

    task automatic check_reads();
        for (int p = 0; p < MN; p++) begin
            logic [MA-1:0] a;
            logic [MD-1:0] d;
            bit            pe;
            a  = m_ra[p*MA +: MA];
            d  = (a == 0) ? '0 : ((m_we && m_wa == a) ? m_wd : mm[a]);
            pe = (a != 0) && mp[a] && !(m_we && m_wa == a);
            chk($sformatf("m_rdata%0d", p), 64'(m_rdata[p*MD +: MD]), 64'(d));
            chk($sformatf("m_rpend%0d", p), 64'(m_rpend[p]), 64'(pe));
        end
        for (int p = 0; p < SN; p++) begin
            logic [SA-1:0] a;
            logic [SD-1:0] d;
            bit            pe;
            a  = s_ra[p*SA +: SA];
            d  = (a == 0) ? '0 : ((s_we && s_wa == a) ? s_wd : sm[a]);
            pe = (a != 0) && sp[a] && !(s_we && s_wa == a);
            chk($sformatf("s_rdata%0d", p), 64'(s_rdata[p*SD +: SD]), 64'(d));
            chk($sformatf("s_rpend%0d", p), 64'(s_rpend[p]), 64'(pe));
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; reads are sampled at +3,
    // the model advances at the edge, and pend_cnt is sampled 1 unit after it.
    task automatic cycle(input bit do_reads);
        #2;
        if (do_reads) check_reads();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 2**MA; i++) begin mm[i] = '0; mp[i] = 1'b0; end
            for (int i = 0; i < 2**SA; i++) begin sm[i] = '0; sp[i] = 1'b0; end
        end else begin
            if (m_we && m_wa != 0) begin mm[m_wa] = m_wd; mp[m_wa] = 1'b0; end
            if (m_rsv && m_rsva != 0) mp[m_rsva] = 1'b1;
            if (s_we && s_wa != 0) begin sm[s_wa] = s_wd; sp[s_wa] = 1'b0; end
            if (s_rsv && s_rsva != 0) sp[s_rsva] = 1'b1;
        end
        #1;
        chk("m_pend_cnt", 64'(m_cnt), 64'(count_m()));
        chk("s_pend_cnt", 64'(s_cnt), 64'(count_s()));
    endtask

    task automatic idle();
        m_we = 1'b0; m_rsv = 1'b0; m_wa = '0; m_rsva = '0; m_wd = '0;
        s_we = 1'b0; s_rsv = 1'b0; s_wa = '0; s_rsva = '0; s_wd = '0;
    endtask

    task automatic randomize_inputs();
        m_we   = 1'($urandom_range(0, 1));
        m_wa   = MA'($urandom);
        m_wd   = $urandom;
        m_rsv  = 1'($urandom_range(0, 1));
        m_rsva = ($urandom_range(0, 5) == 0) ? m_wa : MA'($urandom);
        m_ra   = (MN*MA)'($urandom);
        if ($urandom_range(0, 3) == 0) m_ra[0 +: MA] = m_wa;
        s_we   = 1'($urandom_range(0, 1));
        s_wa   = SA'($urandom);
        s_wd   = SD'($urandom);
        s_rsv  = 1'($urandom_range(0, 1));
        s_rsva = ($urandom_range(0, 4) == 0) ? s_wa : SA'($urandom);
        s_ra   = (SN*SA)'($urandom);
        if ($urandom_range(0, 2) == 0) s_ra[SA +: SA] = s_wa;
        rst    = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        idle();
        m_ra = '0;
        s_ra = '0;
        rst  = 1'b1;
        #1;
        cycle(1'b0);
        rst = 1'b0;

        // Reset clears data written before it
        m_we = 1'b1; m_wa = 5'd5; m_wd = 32'hDEADBEEF;
        cycle(1'b1);
        idle(); rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0; m_ra = {5'd1, 5'd5};
        #2;
        chk("rst_r5", 64'(m_rdata[MD-1:0]), 64'h0);
        chk("rst_rpend", 64'(m_rpend), 64'h0);
        chk("rst_cnt", 64'(m_cnt), 64'h0);
        cycle(1'b1);

        // Write-through bypass, then registered readback on both ports
        m_we = 1'b1; m_wa = 5'd3; m_wd = 32'h12345678; m_ra = {5'd0, 5'd3};
        #2;
        chk("bypass", 64'(m_rdata[MD-1:0]), 64'h12345678);
        cycle(1'b1);
        idle(); m_ra = {5'd3, 5'd3};
        #2;
        chk("readback1", 64'(m_rdata[2*MD-1:MD]), 64'h12345678);
        cycle(1'b1);

        // Register 0 ignores writes and reservations
        m_we = 1'b1; m_wa = 5'd0; m_wd = 32'hFFFFFFFF; m_rsv = 1'b1; m_rsva = 5'd0;
        m_ra = {5'd3, 5'd0};
        cycle(1'b1);
        idle();
        chk("r0_cnt", 64'(m_cnt), 64'h0);

        // Scoreboard on r7: reserve, re-reserve, release by write
        m_rsv = 1'b1; m_rsva = 5'd7; m_ra = {5'd0, 5'd7};
        cycle(1'b1);
        chk("rsv7_cnt", 64'(m_cnt), 64'h1);
        cycle(1'b1);
        idle(); m_we = 1'b1; m_wa = 5'd7; m_wd = 32'hA5A5A5A5;
        #2;
        chk("rel7_rpend", 64'(m_rpend[0]), 64'h0);
        cycle(1'b1);
        chk("rel7_cnt", 64'(m_cnt), 64'h0);

        // Simultaneous write and reserve: same register, then different registers
        m_we = 1'b1; m_wa = 5'd4; m_wd = 32'h0BADF00D; m_rsv = 1'b1; m_rsva = 5'd4;
        m_ra = {5'd7, 5'd4};
        cycle(1'b1);
        chk("wr_rsv_same_cnt", 64'(m_cnt), 64'h1);
        m_wd = 32'h600DCAFE; m_rsva = 5'd9; m_ra = {5'd9, 5'd4};
        cycle(1'b1);
        chk("wr_rsv_diff_cnt", 64'(m_cnt), 64'h1);
        idle();
        cycle(1'b1);

        // Small instance: fill data, reserve every register, three-port read
        for (int r = 1; r < 2**SA; r++) begin
            s_we = 1'b1; s_wa = SA'(r); s_wd = SD'(16'h1111 * r);
            cycle(1'b1);
        end
        idle();
        for (int r = 1; r < 2**SA; r++) begin
            s_rsv = 1'b1; s_rsva = SA'(r);
            cycle(1'b1);
        end
        idle();
        chk("s_full_cnt", 64'(s_cnt), 64'd7);
        s_ra = {3'd6, 3'd2, 3'd5};
        #2;
        chk("s_port0", 64'(s_rdata[SD-1:0]), 64'h5555);
        chk("s_port1", 64'(s_rdata[2*SD-1:SD]), 64'h2222);
        chk("s_port2", 64'(s_rdata[3*SD-1:2*SD]), 64'h6666);
        cycle(1'b1);

        for (int n = 0; n < 800; n++) begin
            randomize_inputs();
            cycle(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
